fp_mul_seq: RTL and testbench



---
 rtl/fp_mul_if.sv | 26 ++
 rtl/fp_mul_seq.sv | 161 ++++++++++++++++
 tb/tb_fp_mul_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle for the sequential FP multiplier.
// master = operand source and result consumer; slave = multiplier.
interface fp_mul_if #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 23
);
    logic [m+n:0] a_in;
    logic [m+n:0] b_in;
    logic         in_valid;
    logic         in_ready;
    logic [m+n:0] c_out;
    logic         out_valid;
    logic         out_ready;
    logic         ovf;
    logic         unf;

    modport master (
        output a_in, b_in, in_valid, out_ready,
        input  in_ready, c_out, out_valid, ovf, unf
    );

    modport slave (
        input  a_in, b_in, in_valid, out_ready,
        output in_ready, c_out, out_valid, ovf, unf
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Multi-cycle FP multiplier: shift-add mantissa product, one multiplier bit per cycle.
// Define FP_MUL_RNE_EN for round-to-nearest-even; default build truncates.
module fp_mul_seq #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 23
) (
    input logic     clk,
    input logic     rst_n,
    fp_mul_if.slave bus
);
    localparam int unsigned W  = m + n + 1;
    localparam int unsigned PW = 2 * n + 2;
    localparam int unsigned EW = m + 2;
    localparam int unsigned CW = $clog2(n + 1);

    localparam logic signed [EW-1:0] Bias    = EW'(2 ** (m - 1) - 1);
    localparam logic signed [EW-1:0] ExpMax  = EW'(2 ** m - 1);
    localparam logic signed [EW-1:0] ExpOne  = EW'(1);
    localparam logic signed [EW-1:0] ExpZero = '0;

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e                state_q, state_d;
    logic                  sign_q, sign_d;
    logic [n:0]            mcand_q, mcand_d;
    logic [n:0]            mplier_q, mplier_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [W-1:0]          c_q, c_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    // Normalisation and (optional) rounding of the finished product
    logic [n-1:0]          frac_f;
    logic signed [EW-1:0]  exp_f;

    always_comb begin
        logic [n-1:0]         frac_n;
        logic signed [EW-1:0] exp_n;
`ifdef FP_MUL_RNE_EN
        logic         guard;
        logic         sticky;
        logic         carry;
        logic [n-1:0] frac_r;
`endif
        if (acc_q[PW-1]) begin
            frac_n = acc_q[2*n:n+1];
            exp_n  = exp_q + ExpOne;
        end else begin
            frac_n = acc_q[2*n-1:n];
            exp_n  = exp_q;
        end
`ifdef FP_MUL_RNE_EN
        guard  = acc_q[PW-1] ? acc_q[n]          : acc_q[n-1];
        sticky = acc_q[PW-1] ? (|acc_q[n-1:0])   : (|acc_q[n-2:0]);
        {carry, frac_r} = {1'b0, frac_n} + {{n{1'b0}}, guard & (sticky | frac_n[0])};
        if (carry) begin
            frac_f = '0;
            exp_f  = exp_n + ExpOne;
        end else begin
            frac_f = frac_r;
            exp_f  = exp_n;
        end
`else
        frac_f = frac_n;
        exp_f  = exp_n;
`endif
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sign_d   = bus.a_in[W-1] ^ bus.b_in[W-1];
                    mcand_d  = {1'b1, bus.a_in[n-1:0]};
                    mplier_d = {1'b1, bus.b_in[n-1:0]};
                    exp_d    = $signed({2'b00, bus.a_in[W-2:n]})
                             + $signed({2'b00, bus.b_in[W-2:n]}) - Bias;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    if (bus.a_in[W-2:0] == '0 || bus.b_in[W-2:0] == '0) begin
                        c_d     = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                if (mplier_q[cnt_q]) acc_d = acc_q + (PW'(mcand_q) << cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(n)) state_d = StNorm;
            end
            StNorm: begin
                if (exp_f >= ExpMax) begin
                    c_d   = {sign_q, {m{1'b1}}, {n{1'b0}}};
                    ovf_d = 1'b1;
                end else if (exp_f <= ExpZero) begin
                    c_d   = {sign_q, {(m + n){1'b0}}};
                    unf_d = 1'b1;
                end else begin
                    c_d = {sign_q, exp_f[m-1:0], frac_f};
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            c_q      <= c_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.c_out     = c_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq: results, latency, back-pressure, async reset.
module tb_fp_mul_seq;
    localparam int unsigned M = 8;
    localparam int unsigned N = 23;
    localparam int NormLat = N + 2;  // edges after the accepting edge until out_valid

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mul_if #(.m(M), .n(N)) bus ();

    fp_mul_seq #(.m(M), .n(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands until accepted, then count edges until out_valid (bounded)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
        int wait_cnt = 0;
        @(negedge clk);
        while (!bus.in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("in_ready_before_issue", bus.in_ready, 1);
        bus.a_in = a;
        bus.b_in = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check({tag, "_out_valid_clr"}, bus.out_valid, 0);
        check({tag, "_flags_clr"}, {bus.ovf, bus.unf}, 0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_c, input logic exp_ovf, input logic exp_unf,
                          input int exp_lat);
        int lat;
        issue(a, b, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_c"}, bus.c_out, exp_c);
        check({tag, "_ovf"}, bus.ovf, exp_ovf);
        check({tag, "_unf"}, bus.unf, exp_unf);
        release_out(tag);
    endtask

    initial begin
        int lat;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_c_out", bus.c_out, 0);
        check("rst_flags", {bus.ovf, bus.unf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_2x3",     32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0, NormLat);
        run_op("mul_1p5sq",   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 0, 0, NormLat);
        run_op("mul_neg",     32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 0, 0, NormLat);
        run_op("zero_a",      32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 0, 0, 0);
        run_op("negzero_a",   32'h8000_0000, 32'h4040_0000, 32'h0000_0000, 0, 0, 0);
        run_op("zero_b",      32'h4040_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
        run_op("overflow",    32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1, 0, NormLat);
        run_op("underflow",   32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 0, 1, NormLat);
`ifdef FP_MUL_RNE_EN
        run_op("round",       32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 0, 0, NormLat);
`else
        run_op("round",       32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 0, 0, NormLat);
`endif

        // Back-pressure: result must hold while a new request waits
        issue(32'h4000_0000, 32'h4040_0000, lat);
        check("bp_lat", lat, NormLat);
        @(negedge clk);
        bus.a_in = 32'h3FC0_0000;
        bus.b_in = 32'h3FC0_0000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_c", bus.c_out, 32'h40C0_0000);
            check("bp_hold_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check("bp_after_hs_valid", bus.out_valid, 0);
        check("bp_after_hs_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("bp_accepted", bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("bp_second_lat", lat, NormLat);
        check("bp_second_c", bus.c_out, 32'h4010_0000);
        release_out("bp_second");

        // Asynchronous reset in the middle of MUL
        @(negedge clk);
        bus.a_in = 32'h4000_0000;
        bus.b_in = 32'h4040_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("mid_mul_busy", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", bus.in_ready, 1);
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_c_out", bus.c_out, 0);
        check("async_rst_flags", {bus.ovf, bus.unf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_2x2", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0, 0, NormLat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
